// File: rtl/add_pkg.sv
// rtl/add_pkg.sv - shared constants, op-mode encoding and segment sizing for the pipelined adder
package add_pkg;

  localparam int DEF_WIDTH  = 64;
  localparam int DEF_STAGES = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int seg_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_segment.sv
// rtl/adder_segment.sv - SEG-bit ripple segment with registered sum, carry-out and overflow
module adder_segment #(
  parameter int SEG = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] sum_q,
  output logic           cout_q,
  output logic           ovf_q
);

  logic [SEG:0]   c;
  logic [SEG-1:0] s;

  assign c[0] = ci;

  for (genvar i = 0; i < SEG; i++) begin : gen_fa
    fulladd u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  // Carry into the top bit differing from carry out of it is signed overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (en) begin
      sum_q  <= s;
      cout_q <= c[SEG];
      ovf_q  <= c[SEG] ^ c[SEG-1];
    end
  end

endmodule

// File: rtl/fulladd.sv
// rtl/fulladd.sv - one-bit full adder cell
module fulladd (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - STAGES-deep segmented adder/subtractor with valid/ready streaming
module pipelined_adder
  import add_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG = seg_width(WIDTH, STAGES);

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : gen_cfg_err
    $error("pipelined_adder: WIDTH must be a positive multiple of STAGES");
  end

  logic              adv;
  logic [WIDTH-1:0]  yp;
  logic              c0;
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] cq;
  logic [STAGES-1:0] oq;
  logic [SEG-1:0]    sq [STAGES];

  // Whole pipe advances or holds together; no bubble collapsing.
  assign adv       = out_ready || !out_valid;
  assign in_ready  = adv;
  assign out_valid = vld[STAGES-1];
  assign yp        = (sub == OP_SUB) ? ~y : y;
  assign c0        = (sub == OP_SUB) ? 1'b1 : cin;
  assign cout      = cq[STAGES-1];
  assign ovf       = oq[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else if (adv) begin
      vld[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        vld[k] <= vld[k-1];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : gen_stage
    localparam int D = STAGES - 1 - k;

    logic [SEG-1:0] a;
    logic [SEG-1:0] b;
    logic           ci;

    if (k == 0) begin : gen_head
      assign a  = x[SEG-1:0];
      assign b  = yp[SEG-1:0];
      assign ci = c0;
    end else begin : gen_skew
      // Stage k sees its operand slices k cycles late, aligned with the incoming carry.
      logic [SEG-1:0] sx [k];
      logic [SEG-1:0] sy [k];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < k; j++) begin
            sx[j] <= '0;
            sy[j] <= '0;
          end
        end else if (adv) begin
          sx[0] <= x[k*SEG +: SEG];
          sy[0] <= yp[k*SEG +: SEG];
          for (int j = 1; j < k; j++) begin
            sx[j] <= sx[j-1];
            sy[j] <= sy[j-1];
          end
        end
      end

      assign a  = sx[k-1];
      assign b  = sy[k-1];
      assign ci = cq[k-1];
    end

    adder_segment #(.SEG(SEG)) u_seg (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (adv),
      .a      (a),
      .b      (b),
      .ci     (ci),
      .sum_q  (sq[k]),
      .cout_q (cq[k]),
      .ovf_q  (oq[k])
    );

    if (D == 0) begin : gen_last
      assign z[k*SEG +: SEG] = sq[k];
    end else begin : gen_deskew
      logic [SEG-1:0] dq [D];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < D; j++) begin
            dq[j] <= '0;
          end
        end else if (adv) begin
          dq[0] <= sq[k];
          for (int j = 1; j < D; j++) begin
            dq[j] <= dq[j-1];
          end
        end
      end

      assign z[k*SEG +: SEG] = dq[D-1];
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - directed and streaming checks of pipelined_adder against an arithmetic model
module tb_pipelined_adder;

  localparam int W = 64;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] z;
  logic         cout;
  logic         ovf;

  int n_vec = 0;
  int n_err = 0;
  int n_out = 0;

  logic [W+1:0] q[$];
  logic         stall_prev = 1'b0;
  logic [W-1:0] hz;
  logic         hc;
  logic         ho;

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // {ovf, cout, z} from plain wide arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic ci, input logic sb);
    logic [W-1:0] bp;
    logic [W:0]   s;
    logic         v;
    bp = sb ? ~b : b;
    s  = {1'b0, a} + {1'b0, bp} + ((sb ? 1'b1 : ci) ? 65'd1 : 65'd0);
    v  = (a[W-1] == bp[W-1]) && (s[W-1] != a[W-1]);
    return {v, s};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      stall_prev <= 1'b0;
    end else begin
      logic [W+1:0] e;
      chk("in_ready_rule", {63'd0, in_ready}, {63'd0, out_ready || !out_valid});
      if (stall_prev) begin
        chk("hold_valid", {63'd0, out_valid}, 64'd1);
        chk("hold_z", z, hz);
        chk("hold_flags", {62'd0, cout, ovf}, {62'd0, hc, ho});
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("z", z, e[W-1:0]);
          chk("cout", {63'd0, cout}, {63'd0, e[W]});
          chk("ovf", {63'd0, ovf}, {63'd0, e[W+1]});
        end
        n_out++;
      end
      if (in_valid && in_ready) q.push_back(model(x, y, cin, sub));
      stall_prev <= out_valid && !out_ready;
      hz <= z;
      hc <= cout;
      ho <= ovf;
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic sb);
    int t;
    x = a; y = b; cin = ci; sub = sb; in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (t >= 50) chk("accept_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_latency(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic sb,
                          input logic [W-1:0] ez, input logic ec, input logic eo);
    int lat;
    send(a, b, ci, sb);
    wait_latency(lat);
    chk({name, "_latency"}, lat, S);
    chk({name, "_z"}, z, ez);
    chk({name, "_cout"}, {63'd0, cout}, {63'd0, ec});
    chk({name, "_ovf"}, {63'd0, ovf}, {63'd0, eo});
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int run;
    int t;

    #2;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_z", z, 64'd0);
    chk("rst_flags", {62'd0, cout, ovf}, 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;

    directed("carry_all", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
    directed("sub_neg", 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    directed("ovf_pos", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    directed("cin_add", 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0000, 1'b1, 1'b0,
             64'h0001_0000_0001_0000, 1'b0, 1'b0);

    // Ten back-to-back beats must come out as one unbroken run of ten.
    base = n_out;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          x = {$urandom, $urandom};
          y = {$urandom, $urandom};
          cin = 1'($urandom);
          sub = 1'($urandom);
          in_valid = 1'b1;
          @(posedge clk);
          #1;
        end
        in_valid = 1'b0;
      end
      begin
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 30) begin
          t++;
          @(negedge clk);
        end
        run = 0;
        while (out_valid && run < 20) begin
          run++;
          @(negedge clk);
        end
        chk("stream_run", run, 10);
      end
    join
    repeat (4) @(posedge clk);
    #1 chk("stream_count", n_out - base, 10);

    // Fill with out_ready low, hold five cycles, then drain.
    out_ready = 1'b0;
    base = n_out;
    for (int i = 0; i < 4; i++) send(64'h1111_0000_0000_0000 * (i + 1), 64'h0000_0000_0000_FFFF, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("drain_count", n_out - base, 4);
    chk("drain_empty", q.size(), 0);

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) begin
      x = 64'hA5A5_0000_1234_0000 + i; y = 64'h0101_0101_0101_0101; cin = 1'b0; sub = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_z", z, 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1 base = n_out;
    directed("postrst", 64'h1234, 64'h1111, 1'b1, 1'b0, 64'h2346, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #1 chk("postrst_count", n_out - base, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
